// File: rtl/alu_pkg.sv
// Shared ALU encodings, request payload and decode helpers for the RV32 ALU and its arbiter.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 2;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
  } alu_req_t;

  // Illegal-op decode: funct3 010/011 rejected; funct7 may only select the alternate op on ADD/SR
  function automatic logic is_illegal(input logic [2:0] f3, input logic [6:0] f7);
    logic ill;
    case (f3)
      F3_SLT, F3_SLTU: ill = 1'b1;
      F3_ADD, F3_SR:   ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      default:         ill = (f7 != F7_BASE);
    endcase
    return ill;
  endfunction

  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU; shift amount taken from in2[4:0].
module alu
  import alu_pkg::*;
(
  input  alu_req_t        req,
  output logic [XLEN-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  logic               alt;

  assign shamt = req.in2[SHAMT_W-1:0];
  assign alt   = (req.funct7 == F7_ALT);

  always_comb begin
    result = '0;
    case (req.funct3)
      F3_ADD:  result = alt ? (req.in1 - req.in2) : (req.in1 + req.in2);
      F3_SLL:  result = req.in1 << shamt;
      F3_XOR:  result = req.in1 ^ req.in2;
      F3_SR:   result = alt ? XLEN'($signed(req.in1) >>> shamt) : (req.in1 >> shamt);
      F3_OR:   result = req.in1 | req.in2;
      F3_AND:  result = req.in1 & req.in2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU; one registered response outstanding at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][XLEN-1:0] req_in1,
  input  logic [NREQ-1:0][XLEN-1:0] req_in2,
  input  logic [NREQ-1:0][2:0]      req_funct3,
  input  logic [NREQ-1:0][6:0]      req_funct7,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [XLEN-1:0]           resp_result,
  output logic                      resp_negative,
  output logic                      resp_zero,
  output logic                      resp_illegal
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic            rr_prio;
  logic            consume_c;
  logic            can_accept_c;
  logic            accept_c;
  logic            idx_c;
  logic            illegal_c;
  logic [NREQ-1:0] grant_c;
  alu_req_t        sel_c;
  logic [XLEN-1:0] alu_result;

  // resp_valid is one-hot, so only the owner's resp_ready can consume
  assign consume_c    = |(resp_valid & resp_ready);
  assign can_accept_c = (state == IDLE) || consume_c;

  always_comb begin
    grant_c = req_valid;
    if (req_valid == 2'b11) begin
      grant_c = ((PRIORITY_MODE == 0) && rr_prio) ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = (can_accept_c && !reset) ? grant_c : '0;
  assign accept_c  = |req_ready;
  assign idx_c     = grant_c[1];

  always_comb begin
    sel_c.in1    = req_in1[idx_c];
    sel_c.in2    = req_in2[idx_c];
    sel_c.funct3 = req_funct3[idx_c];
    sel_c.funct7 = req_funct7[idx_c];
    if (is_shift(req_funct3[idx_c])) begin
      sel_c.in2 = XLEN'(req_in2[idx_c][SHAMT_W-1:0]);
    end
  end

  assign illegal_c = is_illegal(sel_c.funct3, sel_c.funct7);

  alu u_alu (
    .req    (sel_c),
    .result (alu_result)
  );

  // Response register and handshake state; rr_prio names the requester favoured on contention
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_negative <= 1'b0;
      resp_zero     <= 1'b0;
      resp_illegal  <= 1'b0;
      rr_prio       <= 1'b0;
    end else if (accept_c) begin
      state         <= HOLD;
      resp_valid    <= req_ready;
      resp_illegal  <= illegal_c;
      resp_result   <= illegal_c ? '0 : alu_result;
      resp_negative <= !illegal_c && alu_result[XLEN-1];
      resp_zero     <= !illegal_c && (alu_result == '0);
      rr_prio       <= req_ready[0];
    end else if (consume_c) begin
      state      <= IDLE;
      resp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences, random vs reference model.
module tb_alu_arbiter;

  localparam int MODE = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_in1;
  logic [1:0][31:0] req_in2;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][6:0]  req_funct7;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_result;
  logic             resp_negative;
  logic             resp_zero;
  logic             resp_illegal;

  int checks = 0;
  int errors = 0;

  bit          m_held;
  int          m_owner;
  int          m_prio;
  logic [31:0] m_result;
  bit          m_neg, m_zero, m_ill;

  alu_arbiter #(.PRIORITY_MODE(MODE)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_in1       (req_in1),
    .req_in2       (req_in2),
    .req_funct3    (req_funct3),
    .req_funct7    (req_funct7),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_negative (resp_negative),
    .resp_zero     (resp_zero),
    .resp_illegal  (resp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_illegal(input int f3, input int f7);
    if (f3 == 2 || f3 == 3) return 1'b1;
    if (f3 == 0 || f3 == 5) return !(f7 == 0 || f7 == 32);
    return f7 != 0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input int f3, input int f7);
    logic signed [31:0] sa;
    int sh;
    sa = a;
    sh = int'(b) & 31;
    case (f3)
      0:       return (f7 == 32) ? a - b : a + b;
      1:       return a << sh;
      4:       return a ^ b;
      5:       return (f7 == 32) ? 32'(sa >>> sh) : a >> sh;
      6:       return a | b;
      7:       return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_grant();
    bit can;
    can = !m_held || (resp_ready[m_owner] == 1'b1);
    if (reset || !can) return 2'b00;
    if (req_valid == 2'b11) return (MODE == 1 || m_prio == 0) ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  task automatic model_reset();
    m_held = 0; m_owner = 0; m_prio = 0;
    m_result = '0; m_neg = 0; m_zero = 0; m_ill = 0;
  endtask

  task automatic check_model();
    check("req_ready", 32'(req_ready), 32'(ref_grant()));
    check("resp_valid", 32'(resp_valid), m_held ? 32'(1 << m_owner) : 32'd0);
    if (m_held) begin
      check("resp_result", resp_result, m_result);
      check("resp_negative", 32'(resp_negative), 32'(m_neg));
      check("resp_zero", 32'(resp_zero), 32'(m_zero));
      check("resp_illegal", 32'(resp_illegal), 32'(m_ill));
    end
  endtask

  task automatic model_step();
    logic [1:0] g;
    bit consumed;
    int w;
    g = ref_grant();
    consumed = m_held && (resp_ready[m_owner] == 1'b1);
    if (reset) begin
      model_reset();
    end else if (g != 2'b00) begin
      w = (g == 2'b10) ? 1 : 0;
      m_held  = 1;
      m_owner = w;
      m_ill   = ref_illegal(int'(req_funct3[w]), int'(req_funct7[w]));
      m_result = m_ill ? 32'd0 : ref_alu(req_in1[w], req_in2[w], int'(req_funct3[w]),
                                         int'(req_funct7[w]));
      m_neg  = m_result[31];
      m_zero = !m_ill && (m_result == 32'd0);
      m_prio = 1 - w;
    end else if (consumed) begin
      m_held = 0;
    end
  endtask

  // Inputs applied at posedge+1, checked mid-cycle, model advanced in step with the DUT edge
  task automatic cycle(input logic [1:0] v, input logic [1:0] rr);
    req_valid  = v;
    resp_ready = rr;
    #2;
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [6:0] f7);
    req_in1[r] = a; req_in2[r] = b; req_funct3[r] = f3; req_funct7[r] = f7;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(2'b11, 2'b00);
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] res;
    logic        neg, zero, ill;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"add",      32'd5,          32'd7,          3'b000, 7'h00, 32'd12,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"sub_neg",  32'd3,          32'd5,          3'b000, 7'h20, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"xor",      32'h0000_00F0,  32'h0000_00FF,  3'b100, 7'h00, 32'h0000_000F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"sra33",    32'h8000_0000,  32'd33,         3'b101, 7'h20, 32'hC000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"srl33",    32'h8000_0000,  32'd33,         3'b101, 7'h00, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"sll31",    32'd1,          32'd31,         3'b001, 7'h00, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"or",       32'h0000_00F0,  32'h0000_000F,  3'b110, 7'h00, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"and_zero", 32'h0000_00F0,  32'h0000_000F,  3'b111, 7'h00, 32'd0,         1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"sub_zero", 32'd7,          32'd7,          3'b000, 7'h20, 32'd0,         1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"f3_010",   32'd9,          32'd4,          3'b010, 7'h00, 32'd0,         1'b0, 1'b0, 1'b1};
    vecs[10] = '{"add_f7_1", 32'd9,          32'd4,          3'b000, 7'h01, 32'd0,         1'b0, 1'b0, 1'b1};
    vecs[11] = '{"sll_alt",  32'd9,          32'd4,          3'b001, 7'h20, 32'd0,         1'b0, 1'b0, 1'b1};
    vecs[12] = '{"f3_011",   32'd1,          32'd2,          3'b011, 7'h00, 32'd0,         1'b0, 1'b0, 1'b1};
    vecs[13] = '{"sra_mask", 32'hFFFF_FFF0,  32'hFFFF_FFE4,  3'b101, 7'h20, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; req_valid = '0; resp_ready = '0;
    req_in1 = '0; req_in2 = '0; req_funct3 = '0; req_funct7 = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_flags", 32'({resp_negative, resp_zero, resp_illegal}), 32'd0);
    do_reset();

    // Back-to-back single-requester ops, each response consumed as the next is accepted
    for (int i = 0; i < 14; i++) begin
      set_op(0, vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].f7);
      cycle(2'b01, 2'b11);
      check({vecs[i].name, "_valid"}, 32'(resp_valid), 32'd1);
      check({vecs[i].name, "_result"}, resp_result, vecs[i].res);
      check({vecs[i].name, "_flags"}, 32'({resp_negative, resp_zero, resp_illegal}),
            32'({vecs[i].neg, vecs[i].zero, vecs[i].ill}));
    end
    cycle(2'b00, 2'b11);

    // Contention after reset: r0 first, then r1 on the next cycle
    do_reset();
    set_op(0, 32'd3, 32'd5, 3'b000, 7'h20);
    set_op(1, 32'h0000_00F0, 32'h0000_00FF, 3'b100, 7'h00);
    cycle(2'b11, 2'b11);
    check("cont_r0_valid", 32'(resp_valid), 32'd1);
    check("cont_r0_result", resp_result, 32'hFFFF_FFFE);
    check("cont_r0_neg", 32'(resp_negative), 32'd1);
    cycle(2'b10, 2'b11);
    check("cont_r1_valid", 32'(resp_valid), 32'd2);
    check("cont_r1_result", resp_result, 32'h0000_000F);

    // r1 shifts with an over-range in2
    set_op(1, 32'h8000_0000, 32'd33, 3'b101, 7'h20);
    cycle(2'b10, 2'b11);
    check("r1_sra_result", resp_result, 32'hC000_0000);
    check("r1_sra_neg", 32'(resp_negative), 32'd1);
    set_op(1, 32'h8000_0000, 32'd33, 3'b101, 7'h00);
    cycle(2'b10, 2'b11);
    check("r1_srl_result", resp_result, 32'h4000_0000);
    cycle(2'b00, 2'b11);

    // Stall with both pending, then release accepts the next request in the same cycle
    set_op(0, 32'd1, 32'd2, 3'b000, 7'h00);
    cycle(2'b01, 2'b11);
    set_op(1, 32'h0000_00F0, 32'h0000_00FF, 3'b100, 7'h00);
    for (int k = 0; k < 3; k++) begin
      cycle(2'b11, 2'b00);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_result", resp_result, 32'd3);
    end
    cycle(2'b11, 2'b10);
    check("nonowner_ignored", 32'(resp_valid), 32'd1);
    cycle(2'b11, 2'b01);
    check("release_owner", 32'(resp_valid), 32'd2);
    check("release_result", resp_result, 32'h0000_000F);

    // Reset while a response is held
    reset = 1'b1;
    cycle(2'b11, 2'b00);
    reset = 1'b0;
    check("midrst_valid", 32'(resp_valid), 32'd0);
    cycle(2'b11, 2'b11);
    check("midrst_r0_wins", 32'(resp_valid), 32'd1);
    cycle(2'b00, 2'b11);

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 2; r++) begin
        logic [6:0] f7;
        case ($urandom_range(0, 3))
          0, 1:    f7 = 7'h00;
          2:       f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        set_op(r, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
               3'($urandom_range(0, 7)), f7);
      end
      reset = ($urandom_range(0, 59) == 0);
      cycle(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
    end
    reset = 1'b0;
    cycle(2'b00, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin between requesters, 1 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  [1:0]  per-requester operation valid.
REQ-005 SHALL have port req_ready  output  [1:0]  per-requester accept; transfer occurs when valid and ready are both high.
REQ-006 SHALL have port req_in1, req_in2  input  2x32  per-requester signed operands.
REQ-007 SHALL have port req_funct3  input  2x3, and req_funct7  input  2x7, per-requester RV32 operation encoding.
REQ-008 SHALL have port resp_valid  output  [1:0]  one-hot owner of the held response.
REQ-009 SHALL have port resp_ready  input  [1:0]  per-requester response acceptance.
REQ-010 SHALL have port resp_result  output  32  registered ALU result.
REQ-011 SHALL have ports resp_negative, resp_zero, resp_illegal  output  1 each  registered flags.

Function
REQ-012 SHALL share one ALU instance between the two requesters, with at most one response outstanding.
REQ-013 SHALL define can_accept = no response held, or held response consumed this cycle (resp_valid[i] and resp_ready[i]).
REQ-014 SHALL grant at most one requester per cycle, only when can_accept; req_ready is one-hot or zero and never asserted to a requester whose req_valid is low.
REQ-015 SHALL, in round-robin mode with both valid, grant the requester not granted last; with one valid, grant it, including back-to-back.
REQ-016 SHALL update the round-robin pointer only on an accepted transfer.
REQ-017 SHALL register result and flags on accept, asserting resp_valid for the owner exactly one cycle later (latency 1, throughput 1 per cycle).
REQ-018 SHALL hold resp_result, flags and resp_valid stable while the owner's resp_ready is low.
REQ-019 SHALL drive the ALU with in2[4:0] zero-extended for funct3 001 and 101; in2 is passed unmodified otherwise.
REQ-020 SHALL flag illegal: funct3 010 or 011; funct3 000/101 with funct7 not 0000000/0100000; funct3 001/100/110/111 with funct7 nonzero.
REQ-021 SHALL, for an illegal op, register resp_illegal=1, resp_result=0, resp_negative=0, resp_zero=0, and complete the handshake normally.
REQ-022 SHALL register resp_negative = result[31] and resp_zero = (result == 0) for legal ops.
REQ-023 SHALL use two states, IDLE (no response held) and HOLD (response held); IDLE->HOLD on accept; HOLD->IDLE on consume with no new accept; HOLD->HOLD on consume with simultaneous accept, or while stalled.
REQ-024 SHALL ignore resp_ready from the non-owner.

Reset
REQ-025 SHALL, on reset, enter IDLE; resp_valid=00, req_ready=00, resp_result=0, all flags 0.
REQ-026 SHALL, on reset, set the round-robin pointer so requester 0 wins the first contention.
REQ-027 SHALL discard any held response when reset is asserted mid-operation; no response emitted for it.

Structure
REQ-028 SHALL take funct3/funct7 encoding constants and the request struct typedef (in1, in2, funct3, funct7) from shared package alu_pkg.
REQ-029 SHALL instantiate the existing alu module exactly once as its only sub-module; the arbiter holds all state.

Verification
REQ-030 SHALL cover: reset, r0 ADD 5+7, resp_ready=11 -> resp_valid=01 next cycle, result 12, zero 0, negative 0.
REQ-031 SHALL cover: both valid after reset, r0 SUB 3-5, r1 XOR 0xF0^0xFF -> r0 first (0xFFFFFFFE, negative 1), then r1 (0x0000000F), consecutive cycles.
REQ-032 SHALL cover: r1 SRA 0x80000000 by in2=33 -> shift of 1, result 0xC0000000, negative 1; SRL same operands -> 0x40000000.
REQ-033 SHALL cover: resp_ready=00 for 3 cycles with both requests pending -> response stable, req_ready=00; releasing ready accepts the next request the same cycle.
REQ-034 SHALL cover: funct3=010 and ADD with funct7=0000001 -> resp_illegal 1, result 0, zero 0, no stall.
REQ-035 SHALL cover: reset asserted while response held -> resp_valid=00 next cycle; subsequent contention grants r0.
